instr_fetch_unit: RTL

Program-memory side of the bit_serial instruction interface. It is loaded once with a short program through a valid/ready write port. It then serves one instruction word per program-counter value to bit_serial and advances the PC whenever bit_serial asserts o_con_pcincr. It replaces the behavioural instruction memory and PC that the bench currently models, so the processor runs against synthesizable fetch logic.

---
 rtl/instr_fetch_unit.sv | 72 +++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loadable program memory and PC serving one instruction per PC value to bit_serial.
module instr_fetch_unit #(
    parameter int IW = 3,
    parameter int AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load_valid,
    input  logic [IW-1:0] i_load_data,
    input  logic          i_load_last,
    output logic          o_load_ready,
    input  logic          i_pcincr,
    output logic [IW-1:0] o_data_instruction,
    output logic [AW-1:0] o_pc,
    output logic [AW:0]   o_len,
    output logic          o_running,
    output logic          o_wrap
);
    localparam int DEPTH = 2**AW;

    typedef enum logic {LOAD, RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] pc, wr_ptr;
    logic [AW:0]   len;
    logic [IW-1:0] mem [DEPTH];
    logic          beat, done, adv, last_pc;

    assign beat    = i_load_valid && state == LOAD;
    assign done    = beat && (i_load_last || wr_ptr == AW'(DEPTH-1));
    assign adv     = state == RUN && i_pcincr;
    assign last_pc = {1'b0, pc} == len - (AW+1)'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = done ? RUN : state;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc     <= '0;
            wr_ptr <= '0;
            len    <= '0;
            o_wrap <= 1'b0;
        end else begin
            if (beat) wr_ptr <= wr_ptr + AW'(1);
            if (done) begin
                len <= {1'b0, wr_ptr} + (AW+1)'(1);
                pc  <= '0;
            end
            if (adv) pc <= last_pc ? '0 : pc + AW'(1);
            o_wrap <= adv && last_pc;
        end
    end

    // array is deliberately left uncleared by reset; a full reload precedes every RUN
    always_ff @(posedge i_clk) begin
        if (i_rst && beat) mem[wr_ptr] <= i_load_data;
    end

    always_comb begin
        o_load_ready       = state == LOAD;
        o_running          = state == RUN;
        o_pc               = pc;
        o_len              = len;
        o_data_instruction = state == RUN ? mem[pc] : '0;
    end
endmodule
